clock_meter: RTL and testbench

CLOCK_METER -- requirements
Module: clock_meter

---
 rtl/clock_meter_pkg.sv | 27 ++
 rtl/clock_meter_sync.sv | 60 ++++++
 rtl/clock_meter.sv | 206 ++++++++++++++++++++
 tb/tb_clock_meter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// rtl/clock_meter_pkg.sv - shared FSM state type and synchronizer depth limits for clock_meter
//
// Contents:
//   state_t           : measurement FSM states
//   SYNC_STAGES_MIN/MAX : legal synchronizer depth range
//   sync_stages_clamp : folds an out-of-range depth back into the legal range
package clock_meter_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEAS_HIGH = 3'd3,
    ST_MEAS_LOW  = 3'd4,
    ST_REPORT    = 3'd5
  } state_t;

  function automatic int sync_stages_clamp(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/clock_meter_sync.sv
// rtl/clock_meter_sync.sv - input synchronizer with optional two-cycle stability filter
//
// Ports:
//   i_clk : measurement clock
//   i_rst : asynchronous active-high reset, clears every flop
//   i_sig : asynchronous waveform under measurement
//   o_sig : synchronized (and optionally filtered) level
// Build option: CLOCK_METER_GLITCH_FILTER_EN adds the stability filter
// (two extra cycles of latency, single-cycle pulses are rejected).
module clock_meter_sync
  import clock_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_sig
);

  localparam int LP_STAGES = sync_stages_clamp(SYNC_STAGES);

  logic [LP_STAGES-1:0] r_sync;
  logic                 w_sync_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[LP_STAGES-2:0], i_sig};
    end
  end

  assign w_sync_out = r_sync[LP_STAGES-1];

`ifdef CLOCK_METER_GLITCH_FILTER_EN
  // r_hold is the previous synchronizer output; the filtered level only
  // follows when the current and previous samples agree, so a level must
  // persist for two consecutive cycles before it is passed on.
  logic r_hold;
  logic r_filt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_hold <= w_sync_out;
      if (w_sync_out == r_hold) begin
        r_filt <= w_sync_out;
      end
    end
  end

  assign o_sig = r_filt;
`else
  assign o_sig = w_sync_out;
`endif

endmodule

// File: rtl/clock_meter.sv
// rtl/clock_meter.sv - measures high/low time of an asynchronous clock-like input in clk ticks
//
// Ports:
//   clk        : only clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : measurement enable; low holds the block idle (except while reporting)
//   sig_in     : asynchronous waveform under measurement
//   meas_valid : result presented (held until meas_ready)
//   meas_ready : consumer accepts the result
//   t_on/t_off : measured high/low time in ticks
//   period     : t_on + t_off
//   first_lvl  : synchronized input level captured when the measurement armed
//   ovf        : a counter saturated during the measurement
//   stuck      : no edge seen before saturation; measurement aborted
// Build option: CLOCK_METER_GLITCH_FILTER_EN enables the input filter in clock_meter_sync.
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] t_on,
  output logic [CNT_W-1:0] t_off,
  output logic [CNT_W:0]   period,
  output logic             first_lvl,
  output logic             ovf,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LP_CNT_LAST = LP_CNT_MAX - CNT_W'(1);

  logic             w_s;
  logic             r_s_prev;
  logic             w_rise;
  logic             w_fall;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_at_limit;

  logic [CNT_W-1:0] r_t_on;
  logic [CNT_W-1:0] w_t_on_nxt;
  logic [CNT_W-1:0] r_t_off;
  logic [CNT_W-1:0] w_t_off_nxt;
  logic [CNT_W:0]   r_period;
  logic [CNT_W:0]   w_period_nxt;
  logic             r_first_lvl;
  logic             w_first_lvl_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_stuck;
  logic             w_stuck_nxt;

  clock_meter_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(clk),
    .i_rst(rst),
    .i_sig(sig_in),
    .o_sig(w_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_prev <= 1'b0;
    end else begin
      r_s_prev <= w_s;
    end
  end

  assign w_rise     = w_s & ~r_s_prev;
  assign w_fall     = ~w_s & r_s_prev;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  // The increment about to happen would land on the saturation value.
  assign w_at_limit = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_t_on      <= '0;
      r_t_off     <= '0;
      r_period    <= '0;
      r_first_lvl <= 1'b0;
      r_ovf       <= 1'b0;
      r_stuck     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_t_on      <= w_t_on_nxt;
      r_t_off     <= w_t_off_nxt;
      r_period    <= w_period_nxt;
      r_first_lvl <= w_first_lvl_nxt;
      r_ovf       <= w_ovf_nxt;
      r_stuck     <= w_stuck_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_t_on_nxt      = r_t_on;
    w_t_off_nxt     = r_t_off;
    w_period_nxt    = r_period;
    w_first_lvl_nxt = r_first_lvl;
    w_ovf_nxt       = r_ovf;
    w_stuck_nxt     = r_stuck;

    if (!en && (r_state != ST_REPORT)) begin
      // Dropping enable abandons any partial measurement.
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ARM;
        end
        ST_ARM: begin
          w_first_lvl_nxt = w_s;
          w_cnt_nxt       = '0;
          w_t_on_nxt      = '0;
          w_t_off_nxt     = '0;
          w_period_nxt    = '0;
          w_ovf_nxt       = 1'b0;
          w_stuck_nxt     = 1'b0;
          w_state_nxt     = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (w_rise) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_MEAS_HIGH;
          end else if (w_at_limit) begin
            w_cnt_nxt   = LP_CNT_MAX;
            w_ovf_nxt   = 1'b1;
            w_stuck_nxt = 1'b1;
            w_state_nxt = ST_REPORT;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_MEAS_HIGH: begin
          if (w_fall) begin
            w_t_on_nxt  = r_cnt;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_MEAS_LOW;
          end else if (w_at_limit) begin
            // The high phase itself saturated: report it at the ceiling.
            w_cnt_nxt   = LP_CNT_MAX;
            w_t_on_nxt  = LP_CNT_MAX;
            w_ovf_nxt   = 1'b1;
            w_stuck_nxt = 1'b1;
            w_state_nxt = ST_REPORT;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_MEAS_LOW: begin
          if (w_rise) begin
            w_t_off_nxt  = r_cnt;
            w_period_nxt = {1'b0, r_t_on} + {1'b0, r_cnt};
            w_state_nxt  = ST_REPORT;
          end else if (w_at_limit) begin
            w_cnt_nxt    = LP_CNT_MAX;
            w_t_off_nxt  = LP_CNT_MAX;
            w_period_nxt = {1'b0, r_t_on} + {1'b0, LP_CNT_MAX};
            w_ovf_nxt    = 1'b1;
            w_stuck_nxt  = 1'b1;
            w_state_nxt  = ST_REPORT;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_REPORT: begin
          // Results are frozen here; input edges are simply not looked at.
          if (meas_ready) begin
            w_state_nxt = en ? ST_ARM : ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign meas_valid = (r_state == ST_REPORT);
  assign t_on       = r_t_on;
  assign t_off      = r_t_off;
  assign period     = r_period;
  assign first_lvl  = r_first_lvl;
  assign ovf        = r_ovf;
  assign stuck      = r_stuck;

endmodule

// File: tb/tb_clock_meter.sv
// tb/tb_clock_meter.sv - scoreboard bench for clock_meter (CNT_W=8, SYNC_STAGES=2)
module tb_clock_meter;

  localparam int CW = 8;
  localparam int SS = 2;
`ifdef CLOCK_METER_GLITCH_FILTER_EN
  localparam int LAT = SS + 3;
`else
  localparam int LAT = SS + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sig_in;
  logic          meas_valid;
  logic          meas_ready;
  logic [CW-1:0] t_on;
  logic [CW-1:0] t_off;
  logic [CW:0]   period;
  logic          first_lvl;
  logic          ovf;
  logic          stuck;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CW-1:0] on;
    logic [CW-1:0] off;
    logic [CW:0]   per;
    logic          fl;
    logic          ov;
    logic          st;
  } exp_t;

  exp_t sb[$];

  clock_meter #(
    .CNT_W(CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sig_in(sig_in),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .t_on(t_on),
    .t_off(t_off),
    .period(period),
    .first_lvl(first_lvl),
    .ovf(ovf),
    .stuck(stuck)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  function automatic exp_t mk(input int h, input int l, input bit fl, input bit ov, input bit st);
    exp_t e;
    e.on  = CW'(h);
    e.off = CW'(l);
    e.per = (CW + 1)'(h + l);
    e.fl  = fl;
    e.ov  = ov;
    e.st  = st;
    return e;
  endfunction

  task automatic drive(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output bit ok, output int cyc);
    cyc = 0;
    while (meas_valid !== 1'b1 && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    ok = (meas_valid === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; meas_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({meas_valid, t_on, t_off, period, first_lvl, ovf, stuck} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b, want all 0",
               meas_valid, t_on, t_off, period, first_lvl, ovf, stuck);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_valid: got %b want 0", meas_valid);
    end
  endtask

  task automatic test_basic();
    bit ok; int cyc; exp_t e;
    meas_ready = 1'b1; en = 1'b1;
    drive(1'b0, 5);
    sb.push_back(mk(10, 30, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 10);
    drive(1'b0, 30);
    sig_in = 1'b1;
    wait_valid(40, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout: got no meas_valid after %0d cycles, want valid", cyc);
    end else begin
      e = sb.pop_front();
      total++;
      if ({t_on, t_off, period, first_lvl, ovf, stuck} !== {e.on, e.off, e.per, e.fl, e.ov, e.st}) begin
        bad++;
        $display("FAIL basic_result: got on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b, want on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b",
                 t_on, t_off, period, first_lvl, ovf, stuck, e.on, e.off, e.per, e.fl, e.ov, e.st);
      end
      total++;
      if (cyc !== LAT) begin
        bad++;
        $display("FAIL basic_latency: got %0d cycles want %0d", cyc, LAT);
      end
      @(negedge clk);
      total++;
      if (meas_valid !== 1'b0) begin
        bad++;
        $display("FAIL basic_handshake_drop: got valid=%b want 0", meas_valid);
      end
    end
    en = 1'b0;
    drive(1'b0, 4);
  endtask

  task automatic test_stuck();
    bit ok; int cyc; exp_t e;
    sig_in = 1'b0; meas_ready = 1'b1;
    sb.push_back(mk(0, 0, 1'b0, 1'b1, 1'b1));
    en = 1'b1;
    wait_valid(400, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stuck_timeout: got no meas_valid after %0d cycles, want valid", cyc);
    end else begin
      e = sb.pop_front();
      total++;
      if ({t_on, t_off, period, first_lvl, ovf, stuck} !== {e.on, e.off, e.per, e.fl, e.ov, e.st}) begin
        bad++;
        $display("FAIL stuck_result: got on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b, want on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b",
                 t_on, t_off, period, first_lvl, ovf, stuck, e.on, e.off, e.per, e.fl, e.ov, e.st);
      end
      total++;
      if (cyc < 255 || cyc > 259) begin
        bad++;
        $display("FAIL stuck_time: got %0d cycles want 255..259", cyc);
      end
    end
    en = 1'b0;
    drive(1'b0, 4);
  endtask

  task automatic test_hold();
    bit ok; int cyc; exp_t e; exp_t e2;
    meas_ready = 1'b0; en = 1'b1;
    drive(1'b0, 5);
    sb.push_back(mk(7, 13, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 7);
    drive(1'b0, 13);
    sig_in = 1'b1;
    wait_valid(40, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL hold_timeout: got no meas_valid after %0d cycles, want valid", cyc);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < 50; i++) begin
        total++;
        if ({meas_valid, t_on, t_off, period, first_lvl, ovf, stuck} !== {1'b1, e.on, e.off, e.per, e.fl, e.ov, e.st}) begin
          bad++;
          $display("FAIL hold_stable[%0d]: got v=%b on=%0d off=%0d per=%0d, want v=1 on=%0d off=%0d per=%0d",
                   i, meas_valid, t_on, t_off, period, e.on, e.off, e.per);
        end
        sig_in = ((i / 3) % 2) == 0;
        @(negedge clk);
      end
      drive(1'b0, 4);
      sb.push_back(mk(12, 8, 1'b0, 1'b0, 1'b0));
      meas_ready = 1'b1;
      drive(1'b0, 6);
      drive(1'b1, 12);
      drive(1'b0, 8);
      sig_in = 1'b1;
      wait_valid(40, ok, cyc);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL hold_next_timeout: got no meas_valid after %0d cycles, want valid", cyc);
      end else begin
        e2 = sb.pop_front();
        total++;
        if ({t_on, t_off, period, first_lvl, ovf, stuck} !== {e2.on, e2.off, e2.per, e2.fl, e2.ov, e2.st}) begin
          bad++;
          $display("FAIL hold_next_result: got on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b, want on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b",
                   t_on, t_off, period, first_lvl, ovf, stuck, e2.on, e2.off, e2.per, e2.fl, e2.ov, e2.st);
        end
      end
    end
    en = 1'b0;
    drive(1'b0, 4);
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc; exp_t e;
    meas_ready = 1'b1; en = 1'b1;
    drive(1'b0, 5);
    drive(1'b1, 6);
    drive(1'b0, 8);
    total++;
    if (t_on !== CW'(6)) begin
      bad++;
      $display("FAIL rstmid_pre_ton: got %0d want 6", t_on);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({meas_valid, t_on, t_off, period, first_lvl, ovf, stuck} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: got v=%b on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b, want all 0",
               meas_valid, t_on, t_off, period, first_lvl, ovf, stuck);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(9, 15, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 6);
    drive(1'b1, 9);
    drive(1'b0, 15);
    sig_in = 1'b1;
    wait_valid(40, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rstmid_timeout: got no meas_valid after %0d cycles, want valid", cyc);
    end else begin
      e = sb.pop_front();
      total++;
      if ({t_on, t_off, period, first_lvl, ovf, stuck} !== {e.on, e.off, e.per, e.fl, e.ov, e.st}) begin
        bad++;
        $display("FAIL rstmid_result: got on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b, want on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b",
                 t_on, t_off, period, first_lvl, ovf, stuck, e.on, e.off, e.per, e.fl, e.ov, e.st);
      end
    end
    en = 1'b0;
    drive(1'b0, 4);
  endtask

  task automatic test_glitch();
    bit ok; int cyc; exp_t e;
    meas_ready = 1'b1; en = 1'b1;
    drive(1'b0, 6);
`ifdef CLOCK_METER_GLITCH_FILTER_EN
    sb.push_back(mk(5, 7, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1);
    drive(1'b0, 20);
    drive(1'b1, 5);
    drive(1'b0, 7);
`else
    sb.push_back(mk(1, 20, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1);
    drive(1'b0, 20);
`endif
    sig_in = 1'b1;
    wait_valid(40, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL glitch_timeout: got no meas_valid after %0d cycles, want valid", cyc);
    end else begin
      e = sb.pop_front();
      total++;
      if ({t_on, t_off, period, first_lvl, ovf, stuck} !== {e.on, e.off, e.per, e.fl, e.ov, e.st}) begin
        bad++;
        $display("FAIL glitch_result: got on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b, want on=%0d off=%0d per=%0d fl=%b ovf=%b stuck=%b",
                 t_on, t_off, period, first_lvl, ovf, stuck, e.on, e.off, e.per, e.fl, e.ov, e.st);
      end
    end
    en = 1'b0;
    drive(1'b0, 4);
  endtask

  task automatic test_en_drop();
    bit seen;
    meas_ready = 1'b1; en = 1'b1;
    drive(1'b0, 5);
    drive(1'b1, 10);
    en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (meas_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL endrop_no_valid: got valid seen=%b want 0", seen);
    end
    en = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({first_lvl, meas_valid} !== 2'b10) begin
      bad++;
      $display("FAIL endrop_first_lvl: got fl=%b v=%b want fl=1 v=0", first_lvl, meas_valid);
    end
    en = 1'b0;
    drive(1'b0, 4);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; meas_ready = 1'b0;
    test_reset();
    test_basic();
    test_stuck();
    test_hold();
    test_reset_mid();
    test_glitch();
    test_en_drop();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
